spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
//  SPI responder with a local byte-wide register file; the target end of the SPI link driven by the team's SPI master.
//  Oversamples sclk/cs_n/mosi on clk, decodes command/data frames, serves SPI reads/writes, exposes a local register port.
//  Sits at the slave modport side of the SPI interface; the local port is used by on-chip logic and the testbench.
// PARAMETERS
//  NUM_REGS     16      register file depth (2..128); SPI address space is 7 bits
//  SYNC_STAGES  2       synchronizer flops on sclk/cs_n/mosi (>=2)
//  CMD_RESP     8'h00   byte returned on miso during the command byte
// PORTS
//  clk        in   1  system clock; must run >= 8x sclk frequency
//  reset_n    in   1  asynchronous active-low reset
//  cs_n       in   1  SPI chip select, active low (asynchronous to clk)
//  sclk       in   1  SPI clock (asynchronous to clk)
//  mosi       in   1  SPI data in, MSB first
//  miso       out  1  SPI data out, MSB first
//  mode       in   1  0 = SPI mode 0 (CPOL0/CPHA0), 1 = SPI mode 3 (CPOL1/CPHA1); sampled at cs_n fall only
//  reg_addr   in   8  local register address
//  reg_write  in   1  local write strobe, one clk, valid only while ready=1
//  reg_wdata  in   8  local write data
//  reg_rdata  out  8  local read data, registered
//  ready      out  1  1 = no SPI frame active, local port accepts accesses
// BEHAVIOUR
//  Reset: miso=0, reg_rdata=8'h00, ready=0, all registers 8'h00, FSM=IDLE; ready rises 1 clk after reset release if cs_n high.
//  Input path: SYNC_STAGES flops + 1 edge flop per input; rise/fall strobes single-cycle; miso updates <= SYNC_STAGES+2 clk after sclk fall.
//  Sampling: both modes sample mosi on sclk rise, drive miso on sclk fall; bit counter 0..7 counts rises.
//  Frame: byte0 = {rw, addr[6:0]} (rw=1 read); bytes 1..N = data; addr auto-increments per data byte, wraps 127->0.
//  FSM: IDLE -(cs_n fall)-> CMD -(8th rise)-> DATA -(8th rise)-> DATA; any state -(cs_n rise)-> IDLE.
//  IDLE: miso=0, ready=1, bit counter cleared; on cs_n fall load tx shift with CMD_RESP, latch mode.
//  miso = tx_shift[7] while cs_n low; on sclk fall shift left, except the first fall after cs_n fall in mode 3 (pre-bit edge).
//  CMD end: latch rw/addr; if read, load tx shift with reg[addr] (8'h00 if addr>=NUM_REGS) so data byte shifts out next.
//  DATA write: full byte committed to reg[addr] in the clk after 8th rise; addr>=NUM_REGS dropped silently.
//  DATA read: at 8th rise, addr increments and tx shift reloads with next reg[addr]; mosi ignored.
//  cs_n rise mid-byte: partial byte discarded, no write, FSM IDLE next clk; cs_n rise wins over simultaneous 8th rise.
//  ready = (FSM==IDLE) registered; deasserts 1 clk after synchronized cs_n fall.
//  Local read: reg_rdata <= reg[reg_addr] every clk (1-clk latency), 8'h00 if out of range.
//  Local write: reg[reg_addr] <= reg_wdata when reg_write && ready; ignored when ready=0 (no collision with SPI writes).
//  Reset mid-frame: immediate return to reset state; frame resumes only after next cs_n fall.
// STRUCTURE
//  spi_pkg: typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_e; typedef struct packed {logic rw; logic [6:0] addr;} spi_cmd_t;
//           localparams SPI_BYTE_W=8, SPI_ADDR_W=7.
//  Sub-module spi_sync_edge: synchronizer + edge detect, one instance per input (cs_n, sclk, mosi).
//  Top: FSM, bit counter, rx/tx shift registers, register array, local port.
// TESTING
//  Mode 0, write 0x03 then 0x5A -> reg[3]=0x5A; reg_rdata=0x5A 1 clk after reg_addr=3; miso=CMD_RESP during byte0.
//  Mode 3, read cmd 0x83 after reg[3]=0x5A -> miso byte1=0x5A, first mosi bit sampled correctly.
//  Burst write 0x0E, 0x11, 0x22, 0x33 -> reg[14]=0x11, reg[15]=0x22, 0x33 dropped (addr16>=NUM_REGS); read 0x90 -> 0x00.
//  cs_n rises after 5 bits of write data to addr 2 -> reg[2] unchanged, ready=1 within SYNC_STAGES+2 clk.
//  reg_write=1 addr 4 data 0x77 while cs_n low -> ignored, reg[4] unchanged; same access with ready=1 -> reg[4]=0x77.
//  reset_n pulsed low mid-read -> miso=0, ready=0, all regs 0x00; next frame read 0x84 returns 0x00.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI responder register file.
//   spi_state_e : frame FSM states
//   spi_cmd_t   : layout of the command byte {rw, addr}
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam int unsigned SPI_ADDR_W = 7;

  typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_e;

  typedef struct packed {
    logic                  rw;    // 1 = read
    logic [SPI_ADDR_W-1:0] addr;
  } spi_cmd_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous input.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   d_i      : asynchronous input
//   level_o  : synchronized level
//   rise_o   : one-cycle strobe on a synchronized 0->1 transition
//   fall_o   : one-cycle strobe on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  edge_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SyncStages{ResetVal}};
      edge_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      edge_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = level_o & ~edge_q;
  assign fall_o  = ~level_o & edge_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI responder with a local byte-wide register file.
// sclk/cs_n/mosi are oversampled on clk; byte0 of a frame is {rw, addr[6:0]}, following bytes are
// data with the address auto-incrementing (127 wraps to 0). Out-of-range addresses read 8'h00 and
// drop writes.
//   clk, reset_n            : system clock (>= 8x sclk), async active-low reset
//   cs_n, sclk, mosi, miso  : SPI slave pins, MSB first; mode 0 = CPOL0/CPHA0, 1 = CPOL1/CPHA1
//   mode                    : SPI mode, sampled at cs_n fall
//   reg_addr/reg_write/reg_wdata/reg_rdata : local register port, 1-clk read latency
//   ready                   : no SPI frame active, local writes accepted
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int unsigned          NUM_REGS    = 16,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] CMD_RESP   = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs_n,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  mode,
  input  logic [SPI_BYTE_W-1:0] reg_addr,
  input  logic                  reg_write,
  input  logic [SPI_BYTE_W-1:0] reg_wdata,
  output logic [SPI_BYTE_W-1:0] reg_rdata,
  output logic                  ready
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // cs_n resets to the asserted level so a select still held low across reset produces no fall;
  // the interrupted frame is ignored until cs_n rises and falls again.
  spi_sync_edge #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (sclk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (mosi),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{cs_lvl, sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e            state_q;
  logic [2:0]            bit_cnt_q;
  logic [6:0]            rx_q;
  logic [SPI_BYTE_W-1:0] tx_q;
  logic                  skip_q;  // suppress the next shift: mode 3 pre-bit edge or fresh reload
  logic                  rw_q;
  logic [SPI_ADDR_W-1:0] addr_q;
  logic                  ready_q;
  logic                  miso_q;
  logic [SPI_BYTE_W-1:0] rdata_q;
  logic [SPI_BYTE_W-1:0] regs_q [NUM_REGS];

  logic [SPI_BYTE_W-1:0] rx_byte;
  spi_cmd_t              cmd;
  logic                  byte_done;
  logic [SPI_ADDR_W-1:0] rd_addr;
  logic [SPI_BYTE_W-1:0] spi_rd, loc_rd;
  logic                  spi_we, loc_we;

  assign rx_byte   = {rx_q, mosi_lvl};
  assign cmd       = spi_cmd_t'(rx_byte);
  // cs_n rise takes priority over a coincident 8th rise
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7) && !cs_rise;
  // Address whose contents go out in the next byte: the command address, then each successor
  assign rd_addr   = (state_q == CMD) ? cmd.addr : addr_q + 7'd1;
  assign spi_we    = byte_done && (state_q == DATA) && !rw_q;
  assign loc_we    = reg_write && ready_q;

  always_comb begin
    spi_rd = '0;
    loc_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == SPI_ADDR_W'(i)) spi_rd = regs_q[i];
      if (reg_addr == SPI_BYTE_W'(i)) loc_rd = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      skip_q    <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      ready_q <= (state_q == IDLE);
      miso_q  <= (state_q != IDLE) && tx_q[7];
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (cs_fall) begin
            state_q <= CMD;
            tx_q    <= CMD_RESP;
            skip_q  <= mode;  // mode 3 opens with a falling edge that carries no bit
          end
        end
        CMD, DATA: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
          end else if (sclk_rise) begin
            rx_q      <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done) begin
              state_q <= DATA;
              // The fall after the 8th rise must leave the new byte's MSB on miso, not shift it
              skip_q  <= 1'b1;
              if (state_q == CMD) begin
                rw_q   <= cmd.rw;
                addr_q <= cmd.addr;
                tx_q   <= cmd.rw ? spi_rd : '0;
              end else begin
                addr_q <= rd_addr;
                tx_q   <= rw_q ? spi_rd : '0;
              end
            end
          end else if (sclk_fall) begin
            if (skip_q) skip_q <= 1'b0;
            else        tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (spi_we && addr_q == SPI_ADDR_W'(i)) begin
          regs_q[i] <= rx_byte;
        end else if (loc_we && reg_addr == SPI_BYTE_W'(i)) begin
          regs_q[i] <= reg_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= loc_rd;
  end

  assign miso      = miso_q;
  assign ready     = ready_q;
  assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: a vector table of SPI frames with expected miso bytes and
// a local read-back, plus hand sequences for reset, aborted frames, blocked local writes and
// reset in the middle of a read.
module tb_spi_slave_regfile;

  localparam int HALF = 8;  // clk cycles per sclk half period

  logic       clk, reset_n, cs_n, sclk, mosi, miso, mode, reg_write, ready;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int n_checks;
  int n_fail;

  logic [7:0]  rbyte;
  logic [7:0]  rd;
  logic [31:0] got;

  typedef struct packed {
    logic        mode;
    logic [2:0]  nb;
    logic [31:0] mosi;     // frame bytes, byte0 in [31:24]
    logic [31:0] miso;     // expected miso bytes
    logic [3:0]  chk;      // bit 3 = check byte0
    logic [7:0]  rd_addr;  // local read-back afterwards
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [9];

  spi_slave_regfile #(
    .NUM_REGS    (16),
    .SYNC_STAGES (2),
    .CMD_RESP    (8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .mode      (mode),
    .reg_addr  (reg_addr),
    .reg_write (reg_write),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One byte (or its first nbits) as master: drive mosi on the fall, sample miso before the rise
  task automatic spi_byte(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = d[7-i];
      wait_clks(HALF);
      r = {r[6:0], miso};
      sclk = 1'b1;
      wait_clks(HALF);
    end
  endtask

  task automatic spi_frame(input logic m, input int nb, input logic [31:0] mo,
                           output logic [31:0] mi);
    logic [7:0] b;
    mi   = '0;
    mode = m;
    sclk = m;
    wait_clks(HALF);
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int k = 0; k < nb; k++) begin
      spi_byte(mo[31-8*k -: 8], 8, b);
      mi[31-8*k -: 8] = b;
    end
    sclk = m;
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic local_read(input logic [7:0] a, output logic [7:0] d);
    reg_addr = a;
    wait_clks(1);
    d = reg_rdata;
  endtask

  task automatic local_write(input logic [7:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_write = 1'b1;
    wait_clks(1);
    reg_write = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    cs_n      = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    mode      = 1'b0;
    reg_addr  = '0;
    reg_write = 1'b0;
    reg_wdata = '0;

    vecs[0] = '{mode:1'b0, nb:3'd2, mosi:32'h035A_0000, miso:32'h0000_0000, chk:4'b1000,
                rd_addr:8'h03, rdata:8'h5A};
    vecs[1] = '{mode:1'b1, nb:3'd2, mosi:32'h8300_0000, miso:32'h005A_0000, chk:4'b1100,
                rd_addr:8'h03, rdata:8'h5A};
    vecs[2] = '{mode:1'b0, nb:3'd4, mosi:32'h0E11_2233, miso:32'h0000_0000, chk:4'b1000,
                rd_addr:8'h0E, rdata:8'h11};
    vecs[3] = '{mode:1'b1, nb:3'd4, mosi:32'h8E00_0000, miso:32'h0011_2200, chk:4'b1111,
                rd_addr:8'h0F, rdata:8'h22};
    vecs[4] = '{mode:1'b0, nb:3'd2, mosi:32'h9000_0000, miso:32'h0000_0000, chk:4'b1100,
                rd_addr:8'h10, rdata:8'h00};
    vecs[5] = '{mode:1'b0, nb:3'd3, mosi:32'h7FAA_BB00, miso:32'h0000_0000, chk:4'b1000,
                rd_addr:8'h00, rdata:8'hBB};
    vecs[6] = '{mode:1'b1, nb:3'd3, mosi:32'h8000_0000, miso:32'h00BB_0000, chk:4'b1110,
                rd_addr:8'h7F, rdata:8'h00};
    vecs[7] = '{mode:1'b0, nb:3'd2, mosi:32'h05C3_0000, miso:32'h0000_0000, chk:4'b1000,
                rd_addr:8'h05, rdata:8'hC3};
    vecs[8] = '{mode:1'b0, nb:3'd2, mosi:32'h8500_0000, miso:32'h00C3_0000, chk:4'b1100,
                rd_addr:8'hFF, rdata:8'h00};

    // Reset state
    wait_clks(3);
    check("rst_miso", miso, 0);
    check("rst_ready", ready, 0);
    check("rst_rdata", reg_rdata, 0);
    reset_n = 1'b1;
    wait_clks(1);
    check("rst_ready_rise", ready, 1);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      spi_frame(vecs[i].mode, int'(vecs[i].nb), vecs[i].mosi, got);
      for (int b = 0; b < 4; b++) begin
        if (vecs[i].chk[3-b]) begin
          check($sformatf("vec%0d_miso_byte%0d", i, b), got[31-8*b -: 8],
                vecs[i].miso[31-8*b -: 8]);
        end
      end
      local_read(vecs[i].rd_addr, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
    end

    // Frame aborted after 5 data bits: no write, ready back within SYNC_STAGES+2
    local_write(8'h02, 8'h3C);
    mode = 1'b0;
    sclk = 1'b0;
    wait_clks(HALF);
    cs_n = 1'b0;
    wait_clks(HALF);
    spi_byte(8'h02, 8, rbyte);
    spi_byte(8'hFF, 5, rbyte);
    cs_n = 1'b1;
    wait_clks(4);
    check("abort_ready", ready, 1);
    sclk = 1'b0;
    wait_clks(HALF);
    local_read(8'h02, rd);
    check("abort_reg2", rd, 8'h3C);

    // Local write blocked while a frame is active
    cs_n = 1'b0;
    wait_clks(HALF);
    check("busy_ready_low", ready, 0);
    local_write(8'h04, 8'h77);
    cs_n = 1'b1;
    wait_clks(HALF);
    local_read(8'h04, rd);
    check("busy_write_ignored", rd, 8'h00);
    local_write(8'h04, 8'h77);
    local_read(8'h04, rd);
    check("idle_write_taken", rd, 8'h77);

    // Reset in the middle of reading reg[4]
    mode = 1'b0;
    sclk = 1'b0;
    wait_clks(HALF);
    cs_n = 1'b0;
    wait_clks(HALF);
    spi_byte(8'h84, 8, rbyte);
    spi_byte(8'h00, 3, rbyte);
    check("midread_bits", rbyte, 8'h03);
    reset_n = 1'b0;
    wait_clks(1);
    check("midrst_miso", miso, 0);
    check("midrst_ready", ready, 0);
    check("midrst_rdata", reg_rdata, 0);
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(2);
    for (int a = 0; a < 16; a++) begin
      local_read(8'(a), rd);
      check($sformatf("midrst_reg%0d", a), rd, 8'h00);
    end
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clks(HALF);
    spi_frame(1'b0, 2, 32'h8400_0000, got);
    check("postrst_read84", got[23:16], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
